// File: rtl/afifo_pkg.sv
// Shared types and default sizes for the async FIFO read-side blocks.
package afifo_pkg;

    localparam int DSIZE_DEF = 8;
    localparam int ASIZE_DEF = 4;
    localparam int CNT_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } rd_state_e;

endpackage

// File: rtl/afifo_rd_skid.sv
// Two-entry buffer between the FIFO pop port and the downstream valid/ready stream.
module afifo_rd_skid
    import afifo_pkg::*;
#(
    parameter int DSIZE = DSIZE_DEF
) (
    input  logic             rclk,
    input  logic             rrst,
    input  logic             push,
    input  logic [DSIZE-1:0] push_data,
    input  logic             pop,
    output logic [1:0]       occ,
    output logic [DSIZE-1:0] head
);

    // Pointers carry a wrap bit above a 1-bit index: equal means empty,
    // same index with different wrap means full.
    logic [1:0]       wr_ptr;
    logic [1:0]       rd_ptr;
    logic [DSIZE-1:0] mem [2];
    logic             empty;
    logic             full;

    always_ff @(posedge rclk or negedge rrst) begin
        if (!rrst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values regardless of block order.
            if (push) wr_ptr <= wr_ptr + 2'd1;
            if (pop)  rd_ptr <= rd_ptr + 2'd1;
        end
    end

    // NOTE: storage has no reset; head is forced to zero whenever the buffer is empty.
    always_ff @(posedge rclk) begin
        if (push) mem[wr_ptr[0]] <= push_data;
    end

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[1] != rd_ptr[1]) && (wr_ptr[0] == rd_ptr[0]);
    assign occ   = full ? 2'd2 : (empty ? 2'd0 : 2'd1);
    assign head  = empty ? '0 : mem[rd_ptr[0]];

endmodule

// File: rtl/afifo_rd_drain.sv
// Read-side drain: pops len words from the async FIFO and forwards them on a
// valid/ready stream, with abort, a done pulse and a saturating pop counter.
module afifo_rd_drain
    import afifo_pkg::*;
#(
    parameter int DSIZE = DSIZE_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             rclk,
    input  logic             rrst,
    input  logic             rempty,
    input  logic [DSIZE-1:0] rdata,
    output logic             rinc,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             abort,
    output logic             m_valid,
    output logic [DSIZE-1:0] m_data,
    input  logic             m_ready,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [CNT_W-1:0] rd_count
);

    rd_state_e        state;
    rd_state_e        state_d;
    logic [CNT_W-1:0] remaining;
    logic [1:0]       occ;
    logic             accept;

    assign m_valid = (occ != 2'd0);
    assign accept  = m_valid && m_ready;

    afifo_rd_skid #(.DSIZE(DSIZE)) u_skid (
        .rclk      (rclk),
        .rrst      (rrst),
        .push      (rinc),
        .push_data (rdata),
        .pop       (accept),
        .occ       (occ),
        .head      (m_data)
    );

    always_ff @(posedge rclk or negedge rrst) begin
        if (!rrst) state <= IDLE;
        else       state <= state_d;
    end

    always_comb begin
        // NOTE: default first so every path assigns state_d and no latch is inferred.
        state_d = state;
        case (state)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (remaining == '0 || abort) state_d = FLUSH;
            FLUSH:   if (occ == 2'd0) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // rinc never looks at m_ready, so there is no combinational path from downstream ready.
    always_comb begin
        rinc = 1'b0;
        busy = (state != IDLE);
        done = (state == FLUSH) && (occ == 2'd0);
        if (state == RUN) begin
            rinc = !rempty && (occ != 2'd2) && (remaining != '0) && !abort;
        end
    end

    always_ff @(posedge rclk or negedge rrst) begin
        if (!rrst) begin
            remaining <= '0;
            rd_count  <= '0;
            aborted   <= 1'b0;
        end else if (state == IDLE && start) begin
            remaining <= len;
            rd_count  <= '0;
            aborted   <= 1'b0;
        end else begin
            if (rinc) begin
                remaining <= remaining - 1'b1;
                if (rd_count != '1) rd_count <= rd_count + 1'b1;
            end
            if (state == RUN && abort) aborted <= 1'b1;
        end
    end

endmodule

// File: tb/tb_afifo_rd_drain.sv
// Randomized bench for afifo_rd_drain against a queue-based behavioural model.
module tb_afifo_rd_drain;

    localparam int DSIZE = 8;
    localparam int CNT_W = 16;

    logic             rclk = 1'b0;
    logic             rrst = 1'b1;
    logic             rempty = 1'b1;
    logic [DSIZE-1:0] rdata = '0;
    logic             rinc;
    logic             start = 1'b0;
    logic [CNT_W-1:0] len = '0;
    logic             abort = 1'b0;
    logic             m_valid;
    logic [DSIZE-1:0] m_data;
    logic             m_ready = 1'b0;
    logic             busy;
    logic             done;
    logic             aborted;
    logic [CNT_W-1:0] rd_count;

    int checks = 0;
    int failures = 0;

    afifo_rd_drain #(.DSIZE(DSIZE), .CNT_W(CNT_W)) dut (
        .rclk     (rclk),
        .rrst     (rrst),
        .rempty   (rempty),
        .rdata    (rdata),
        .rinc     (rinc),
        .start    (start),
        .len      (len),
        .abort    (abort),
        .m_valid  (m_valid),
        .m_data   (m_data),
        .m_ready  (m_ready),
        .busy     (busy),
        .done     (done),
        .aborted  (aborted),
        .rd_count (rd_count)
    );

    always #5 rclk = ~rclk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // FIFO source emulation and reference model state
    logic [DSIZE-1:0] src[$];
    logic [DSIZE-1:0] bq[$];
    logic             stall = 1'b0;
    logic             src_pop = 1'b0;
    int  ph = 0;          // 0 idle, 1 run, 2 flush
    int  rem = 0;
    int  cnt = 0;
    bit  ab = 1'b0;
    int  sz0, rem0;
    bit  e_rinc, e_valid, e_done;
    logic [DSIZE-1:0] e_data;
    int  cyc = 0, xfer_pops = 0, delivered = 0;
    int  start_cyc = -1, done_cyc = -1, last_acc_cyc = -1;
    int  first_pop_cyc = -1, last_pop_cyc = -1;

    always @(negedge rclk) begin
        #1;
        if (src_pop && src.size() > 0) void'(src.pop_front());
        src_pop = 1'b0;
        rempty  = stall || (src.size() == 0);
        rdata   = (src.size() > 0) ? src[0] : DSIZE'($urandom);
        #1;
        cyc++;
        if (!rrst) begin
            ph = 0; rem = 0; cnt = 0; ab = 1'b0; bq = {};
        end
        e_valid = (bq.size() != 0);
        e_data  = e_valid ? bq[0] : '0;
        e_rinc  = (ph == 1) && !rempty && (bq.size() < 2) && (rem != 0) && !abort;
        e_done  = (ph == 2) && (bq.size() == 0);
        check("rinc",     rinc,     e_rinc);
        check("m_valid",  m_valid,  e_valid);
        check("m_data",   m_data,   e_data);
        check("busy",     busy,     ph != 0);
        check("done",     done,     e_done);
        check("aborted",  aborted,  ab);
        check("rd_count", rd_count, cnt);
        if (rrst) begin
            sz0  = bq.size();
            rem0 = rem;
            src_pop = rinc;
            if (rinc) begin
                xfer_pops++;
                last_pop_cyc = cyc;
                if (first_pop_cyc < 0) first_pop_cyc = cyc;
            end
            if (e_valid && m_ready) begin
                void'(bq.pop_front());
                delivered++;
                last_acc_cyc = cyc;
            end
            if (e_rinc) begin
                bq.push_back(rdata);
                rem--;
                if (cnt < 2**CNT_W - 1) cnt++;
            end
            if (e_done) done_cyc = cyc;
            case (ph)
                0: if (start) begin
                    ph = 1; rem = int'(len); cnt = 0; ab = 1'b0;
                    start_cyc = cyc; xfer_pops = 0; delivered = 0; first_pop_cyc = -1;
                end
                1: if (rem0 == 0 || abort) begin
                    ph = 2;
                    if (abort) ab = 1'b1;
                end
                default: if (sz0 == 0) ph = 0;
            endcase
        end
    end

    bit rdy_rand = 1'b0;
    bit abort_rand = 1'b0;
    int stall_mode = 0;   // 0 none, 1 toggle every 3 clks, 2 random

    task automatic tick();
        @(negedge rclk);
        start = 1'b0;
        abort = abort_rand && ($urandom_range(0, 29) == 0);
        if (rdy_rand) m_ready = ($urandom_range(0, 9) < 7);
        case (stall_mode)
            1:       stall = ((cyc / 3) % 2) == 1;
            2:       stall = ($urandom_range(0, 3) == 0);
            default: stall = 1'b0;
        endcase
    endtask

    task automatic fill(input int n);
        for (int i = 0; i < n; i++) src.push_back(DSIZE'($urandom));
    endtask

    task automatic begin_xfer(input int n, input bit with_abort);
        tick();
        start = 1'b1;
        len   = CNT_W'(n);
        abort = with_abort;
    endtask

    task automatic wait_done(input int budget, input string name);
        bit seen = 1'b0;
        for (int k = 0; k < budget && !seen; k++) begin
            tick();
            #3;
            if (done === 1'b1) seen = 1'b1;
        end
        if (!seen) check({name, "_done_timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        #1 rrst = 1'b0;
        m_ready = 1'b1;
        repeat (3) tick();
        tick();
        rrst = 1'b1;

        // streaming, full throughput
        src = {}; fill(8);
        begin_xfer(8, 1'b0);
        wait_done(40, "t2");
        check("t2_pops", xfer_pops, 8);
        check("t2_rd_count", rd_count, 8);
        check("t2_consecutive", last_pop_cyc - first_pop_cyc, 7);
        check("t2_done_latency", done_cyc - last_acc_cyc, 1);
        check("t2_aborted", aborted, 0);

        // back-pressure
        tick(); src = {}; fill(4);
        m_ready = 1'b0;
        begin_xfer(4, 1'b0);
        repeat (6) tick();
        #3;
        check("t3_pops_stalled", xfer_pops, 2);
        tick();
        m_ready = 1'b1;
        wait_done(40, "t3");
        check("t3_pops", xfer_pops, 4);
        check("t3_delivered", delivered, 4);

        // empty stall
        tick(); src = {}; fill(5);
        stall_mode = 1;
        begin_xfer(5, 1'b0);
        wait_done(80, "t4");
        check("t4_pops", xfer_pops, 5);
        check("t4_aborted", aborted, 0);
        stall_mode = 0;

        // abort after 3 pops
        tick(); src = {}; fill(10);
        begin_xfer(10, 1'b0);
        for (int k = 0; k < 20; k++) begin
            tick();
            if (xfer_pops == 3) begin
                abort = 1'b1;
                break;
            end
        end
        wait_done(20, "t5");
        check("t5_rd_count", rd_count, 3);
        check("t5_aborted", aborted, 1);
        check("t5_delivered", delivered, 3);

        // len = 0
        tick(); src = {};
        begin_xfer(0, 1'b0);
        wait_done(10, "t6a");
        check("t6a_done_delay", done_cyc - start_cyc, 2);
        check("t6a_pops", xfer_pops, 0);

        // start during RUN ignored
        tick(); src = {}; fill(6);
        begin_xfer(6, 1'b0);
        tick(); tick();
        start = 1'b1;
        len = CNT_W'(2);
        wait_done(40, "t6b");
        check("t6b_pops", xfer_pops, 6);
        check("t6b_rd_count", rd_count, 6);

        // start + abort together in IDLE
        tick(); src = {}; fill(3);
        begin_xfer(3, 1'b1);
        wait_done(30, "t6c");
        check("t6c_pops", xfer_pops, 3);
        check("t6c_aborted", aborted, 0);

        // reset mid-RUN with a full buffer
        tick(); src = {}; fill(6);
        m_ready = 1'b0;
        begin_xfer(6, 1'b0);
        repeat (4) tick();
        #3;
        check("t1_occ_full", m_valid, 1);
        tick();
        rrst = 1'b0;
        #3;
        check("t1_rinc", rinc, 0);
        check("t1_m_valid", m_valid, 0);
        check("t1_rd_count", rd_count, 0);
        check("t1_busy", busy, 0);
        tick();
        rrst = 1'b1;
        m_ready = 1'b1;
        tick(); src = {};

        // randomized transfers
        rdy_rand = 1'b1;
        stall_mode = 2;
        for (int t = 0; t < 40; t++) begin
            int n;
            tick(); src = {};
            n = $urandom_range(0, 12);
            fill(n);
            abort_rand = 1'b0;
            begin_xfer(n, $urandom_range(0, 7) == 0);
            abort_rand = ($urandom_range(0, 3) == 0);
            wait_done(400, "rnd");
            abort_rand = 1'b0;
            check("rnd_delivered", delivered, xfer_pops);
            if (!ab) check("rnd_pops", xfer_pops, n);
        end
        rdy_rand = 1'b0;
        stall_mode = 0;

        repeat (2) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
